if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction fetch unit: the producer of the `pc`/`instr` pair that the decode stage consumes.
- Owns the program counter and issues in-order word requests to the instruction memory port.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/exception target) that flushes buffered and in-flight fetches.

Parameters:
- PC_SIZE, 32, PC width (matches `PC_SIZE`)
- INSTR_SIZE, 32, instruction width (matches `INSTR_SIZE`)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_SIZE  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance; no ready (always accepted)
- imem_rsp_data  in  INSTR_SIZE  instruction word
- imem_rsp_err  in  1  bus/access fault for this response
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  PC_SIZE  new fetch address; bits [1:0] ignored (treated 0)
- instr_valid  out  1  FIFO head valid to decode
- instr_ready  in  1  decode consumes head
- pc  out  PC_SIZE  PC of head instruction
- instr  out  INSTR_SIZE  head instruction word
- instr_err  out  1  head carries fetch fault

Behaviour:
Reset (async assert, sync release):
- fetch_pc = RESET_PC, rsp_pc = RESET_PC; FIFO empty.
- outstanding = 0, drop_cnt = 0.
- imem_req_valid = 0, instr_valid = 0, pc/instr/instr_err = 0.

Request side:
- credits = FIFO_DEPTH − fifo_count − outstanding.
- imem_req_valid = (credits > 0) && !redirect_valid. Combinational; the memory port tolerates withdrawal.
- imem_req_addr = fetch_pc.
- Accept on imem_req_valid && imem_req_ready: fetch_pc += 4 (wraps modulo 2^PC_SIZE); outstanding +1.
- First request may assert in the first cycle after rst_n release.

Response side:
- Each imem_rsp_valid: outstanding −1.
- If drop_cnt > 0 or redirect_valid in the same cycle: response discarded; drop_cnt −1 when drop_cnt > 0.
- Otherwise push {rsp_pc, data, err}; rsp_pc += 4.
- Accept and response in the same cycle: outstanding unchanged.
- Credits guarantee no push into a full FIFO. A push with the FIFO full is an assertion failure.

Decode side:
- instr_valid = FIFO non-empty; pc/instr/instr_err = head entry (registered FIFO storage).
- Pop on instr_valid && instr_ready. Push and pop in the same cycle are both allowed at any occupancy.
- Min latency is response cycle +1: data arriving at cycle N is visible at N+1.
- Head outputs hold stable while instr_valid && !instr_ready.

Redirect (one-cycle pulse, highest priority):
- That cycle: no request issued, no push, any pop ignored.
- Next cycle: FIFO empty, instr_valid = 0, fetch_pc = rsp_pc = {redirect_pc[PC_SIZE-1:2], 2'b00}.
- drop_cnt_next = (outstanding − (imem_rsp_valid ? 1 : 0)). All surviving in-flight responses are discarded.
- Requests to the new PC may issue the cycle after redirect, even while drop_cnt > 0. Credits still count dropped-pending requests through outstanding.
- Back-to-back redirects: last one wins; drop_cnt recomputed each time.

Errors:
- instr_err is passed through per entry; the fetch unit does not stop on error. Decode/trap logic issues the redirect.

Test Plan:
1. Reset release, imem latency 1, req_ready=1, instr_ready=1 → requests 0x0, 0x4, 0x8…; decode sees pc 0x0/0x4/0x8 with matching data; instr_valid first high 2 cycles after first request.
2. instr_ready=0, FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; instr_valid held, pc=0x0 stable. Raising instr_ready resumes one request per pop.
3. imem_req_ready=0 for 3 cycles → imem_req_addr stays 0x8, no fetch_pc advance; issue resumes on ready.
4. Two requests in flight (0x10, 0x14), redirect_valid with redirect_pc=0x203 → both responses discarded; next request addr 0x200; first decode entry pc=0x200.
5. Redirect in the same cycle as a response and a decode pop → response dropped, drop_cnt = outstanding−1, FIFO empty next cycle, no underflow/overflow.
6. Response with imem_rsp_err=1 at pc 0x8 → entry pc=0x8, instr_err=1; following entries instr_err=0; fetch continues. fetch_pc=0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches and
// buffers {pc, instr, err} entries for decode behind a valid/ready handshake.
// Redirects flush the buffer and discard every response already in flight.
module if_fetch #(
  parameter int                  PC_SIZE    = 32,
  parameter int                  INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]  RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [PC_SIZE-1:0]    redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [PC_SIZE-1:0]    pc,
  output logic [INSTR_SIZE-1:0] instr,
  output logic                  instr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_SIZE-1:0]    pc;
    logic [INSTR_SIZE-1:0] ins;
    logic                  err;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      out_q, out_d;     // requests accepted, response pending
  logic [CW-1:0]      drop_q, drop_d;   // pending responses to discard
  logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_SIZE-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW:0]        used;
  logic               accept, push, pop;
  logic [PC_SIZE-1:0] redir_al;
  logic               unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];
  assign redir_al   = {redirect_pc[PC_SIZE-1:2], 2'b00};

  // Buffer slots are reserved at request time, so credits = depth - used.
  assign used           = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = rst_n && (used < {1'b0, DEPTH_C}) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (cnt_q != '0);
  assign pc          = mem_q[rd_q].pc;
  assign instr       = mem_q[rd_q].ins;
  assign instr_err   = mem_q[rd_q].err;

  // Next-state for PCs, counters and pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    if (accept) fetch_pc_d = fetch_pc_q + PC_SIZE'(4);
    if (push)   rsp_pc_d   = rsp_pc_q + PC_SIZE'(4);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect_valid) begin
      fetch_pc_d = redir_al;
      rsp_pc_d   = redir_al;
      drop_d     = out_q - CW'(imem_rsp_valid);
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= '{pc: rsp_pc_q, ins: imem_rsp_data, err: imem_rsp_err};
    end
  end

  // Credit accounting must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_if_fetch.sv
// Directed per-cycle vectors for if_fetch: each row drives one cycle of
// memory/decode/redirect inputs and states the outputs expected that cycle.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] pc, instr;
  logic        instr_err;

  int checks = 0;
  int errors = 0;
  int row    = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .instr(instr), .instr_err(instr_err)
  );

  typedef struct {
    logic        rq_rdy;
    logic        rs_v;
    logic [31:0] rs_d;
    logic        rs_e;
    logic        rd_v;
    logic [31:0] rd_pc;
    logic        in_rdy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic rq_rdy, logic rs_v, logic [31:0] rs_d, logic rs_e,
                              logic rd_v, logic [31:0] rd_pc, logic in_rdy,
                              logic e_rqv, logic [31:0] e_addr, logic e_iv,
                              logic [31:0] e_pc, logic [31:0] e_ins, logic e_err);
    vec_t v;
    v.rq_rdy = rq_rdy; v.rs_v = rs_v; v.rs_d = rs_d; v.rs_e = rs_e;
    v.rd_v = rd_v; v.rd_pc = rd_pc; v.in_rdy = in_rdy;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d act=%h exp=%h", name, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check just after.
  task automatic apply(input vec_t v);
    @(negedge clk);
    imem_req_ready = v.rq_rdy;
    imem_rsp_valid = v.rs_v;
    imem_rsp_data  = v.rs_d;
    imem_rsp_err   = v.rs_e;
    redirect_valid = v.rd_v;
    redirect_pc    = v.rd_pc;
    instr_ready    = v.in_rdy;
    #1;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, v.e_rqv});
    chk("req_addr", imem_req_addr, v.e_addr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, v.e_iv});
    if (v.e_iv) begin
      chk("pc", pc, v.e_pc);
      chk("instr", instr, v.e_ins);
      chk("instr_err", {31'b0, instr_err}, {31'b0, v.e_err});
    end
    row++;
  endtask

  vec_t tbl[$];

  initial begin
    //                rdy rv data         re rdv rdpc         ir | rqv addr         iv pc           ins          err
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0000, 0, 0, 32'h0,        1,  1, 32'h4,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0004, 0, 0, 32'h0,        1,  1, 32'h8,        1, 32'h0,        32'h1000_0000, 0));
    tbl.push_back(mk(1, 1, 32'h1000_0008, 1, 0, 32'h0,        1,  1, 32'hC,        1, 32'h4,        32'h1000_0004, 0));
    tbl.push_back(mk(1, 1, 32'h1000_000C, 0, 0, 32'h0,        1,  1, 32'h10,       1, 32'h8,        32'h1000_0008, 1));
    // decode stalls: buffer fills, requests stop at 4 slots used
    tbl.push_back(mk(1, 1, 32'h1000_0010, 0, 0, 32'h0,        0,  1, 32'h14,       1, 32'hC,        32'h1000_000C, 0));
    tbl.push_back(mk(1, 1, 32'h1000_0014, 0, 0, 32'h0,        0,  1, 32'h18,       1, 32'hC,        32'h1000_000C, 0));
    tbl.push_back(mk(1, 1, 32'h1000_0018, 0, 0, 32'h0,        0,  0, 32'h1C,       1, 32'hC,        32'h1000_000C, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  0, 32'h1C,       1, 32'hC,        32'h1000_000C, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1,  0, 32'h1C,       1, 32'hC,        32'h1000_000C, 0));
    // memory not ready: address holds
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h1C,       1, 32'h10,       32'h1000_0010, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h1C,       1, 32'h10,       32'h1000_0010, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h1C,       1, 32'h10,       32'h1000_0010, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h1C,       1, 32'h10,       32'h1000_0010, 0));
    tbl.push_back(mk(1, 1, 32'h1000_001C, 0, 0, 32'h0,        1,  0, 32'h20,       1, 32'h10,       32'h1000_0010, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h20,       1, 32'h14,       32'h1000_0014, 0));
    tbl.push_back(mk(1, 1, 32'h1000_0020, 0, 0, 32'h0,        1,  1, 32'h24,       1, 32'h18,       32'h1000_0018, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h28,       1, 32'h1C,       32'h1000_001C, 0));
    // redirect with 0x24/0x28 in flight; pop in that cycle is ignored
    tbl.push_back(mk(1, 0, 32'h0,        0, 1, 32'h203,       1,  0, 32'h2C,       1, 32'h1C,       32'h1000_001C, 0));
    tbl.push_back(mk(1, 1, 32'h1000_0024, 0, 0, 32'h0,        1,  1, 32'h200,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0028, 0, 0, 32'h0,        1,  1, 32'h204,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0200, 0, 0, 32'h0,        1,  1, 32'h208,      0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0204, 0, 0, 32'h0,        1,  1, 32'h20C,      1, 32'h200,      32'h1000_0200, 0));
    // redirect + response + pop together, target near the top of the space
    tbl.push_back(mk(1, 1, 32'h1000_0208, 0, 1, 32'hFFFF_FFFE, 1, 0, 32'h210,      1, 32'h204,      32'h1000_0204, 0));
    tbl.push_back(mk(1, 1, 32'h1000_020C, 0, 0, 32'h0,        1,  1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,        0));
    tbl.push_back(mk(1, 1, 32'hCAFE_F00D, 0, 0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h1000_0000, 0, 0, 32'h0,        1,  1, 32'h4,        1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h8,        1, 32'h0,        32'h1000_0000, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'hC,        0, 32'h0,        32'h0,        0));

    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_err", {31'b0, instr_err}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Back-to-back redirects with 0x4/0x8 outstanding: each recomputes the
    // drop count, so the response arriving after the second one is kept.
    apply(mk(1, 1, 32'h1000_0004, 0, 1, 32'h300, 0, 0, 32'hC,   0, 32'h0,   32'h0,         0));
    apply(mk(1, 1, 32'h1000_0008, 0, 1, 32'h404, 0, 0, 32'h300, 0, 32'h0,   32'h0,         0));
    apply(mk(1, 0, 32'h0,         0, 0, 32'h0,   0, 1, 32'h404, 0, 32'h0,   32'h0,         0));
    apply(mk(1, 1, 32'h55AA_0404, 0, 0, 32'h0,   0, 1, 32'h408, 0, 32'h0,   32'h0,         0));
    apply(mk(0, 0, 32'h0,         0, 0, 32'h0,   0, 1, 32'h40C, 1, 32'h404, 32'h55AA_0404, 0));

    // Asynchronous reset mid-run clears the buffer immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("arst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
